// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, operand addresses and FSM states shared by the command frame decoder.
package cmd_pkg;
   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A,
      ALU_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD
   } state_t;

   // States that expect another byte of the current frame
   function automatic logic byte_wait(state_t s);
      return s inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};
   endfunction

   // States that are busy with an operation and cannot take bytes
   function automatic logic busy(state_t s);
      return s inside {RD_WAIT, ALU_WAIT, TX_LSB, TX_MSB, TX_RD};
   endfunction
endpackage

// File: rtl/frame_timeout_cnt.sv
// frame_timeout_cnt: idle-cycle counter that flags expiry after TIMEOUT_CYC-1 counted cycles.
module frame_timeout_cnt #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT_CYC);

   logic [CW-1:0] r_cnt;

   assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr || o_expire)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: parses rx bytes into register-file / ALU commands and
// streams result bytes out over a valid/ready interface.
module cmd_frame_decoder
   import cmd_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int FUN_WIDTH     = 4,
   parameter int TIMEOUT_CYC   = 1024
) (
   input  logic                     D_CLK,
   input  logic                     D_RST,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_valid,
   output logic [ADDR_WIDTH-1:0]    rf_addr,
   output logic [DATA_WIDTH-1:0]    rf_wr_data,
   output logic                     rf_wr_en,
   output logic                     rf_rd_en,
   input  logic [DATA_WIDTH-1:0]    rf_rd_data,
   input  logic                     rf_rd_valid,
   output logic [FUN_WIDTH-1:0]     alu_fun,
   output logic                     alu_en,
   input  logic [ALU_OUT_WIDTH-1:0] alu_out,
   input  logic                     alu_out_valid,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     frame_err
);
   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_alu_msb;
   logic                  w_wait;
   logic                  w_expire;

   assign w_wait = byte_wait(r_state);

   frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .i_clk    (D_CLK),
      .i_rst_n  (D_RST),
      .i_clr    (!w_wait || rx_valid),
      .i_en     (w_wait && !rx_valid),
      .o_expire (w_expire)
   );

   always_ff @(posedge D_CLK) begin
      if (!D_RST) begin
         r_state    <= IDLE;
         r_alu_msb  <= '0;
         rf_addr    <= '0;
         rf_wr_data <= '0;
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         alu_fun    <= '0;
         alu_en     <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rf_wr_en  <= 1'b0;
         rf_rd_en  <= 1'b0;
         alu_en    <= 1'b0;
         frame_err <= rx_valid && busy(r_state);
         if (w_expire) begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (rx_valid) begin
                  if (rx_data == DATA_WIDTH'(CMD_RF_WR))        r_state <= WR_ADDR;
                  else if (rx_data == DATA_WIDTH'(CMD_RF_RD))   r_state <= RD_ADDR;
                  else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  r_state <= ALU_A;
                  else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) r_state <= ALU_FUN;
                  else                                          frame_err <= 1'b1;
               end
               WR_ADDR: if (rx_valid) begin
                  rf_addr <= rx_data[ADDR_WIDTH-1:0];
                  r_state <= WR_DATA;
               end
               WR_DATA: if (rx_valid) begin
                  rf_wr_data <= rx_data;
                  rf_wr_en   <= 1'b1;
                  r_state    <= IDLE;
               end
               RD_ADDR: if (rx_valid) begin
                  rf_addr  <= rx_data[ADDR_WIDTH-1:0];
                  rf_rd_en <= 1'b1;
                  r_state  <= RD_WAIT;
               end
               RD_WAIT: if (rf_rd_valid) begin
                  tx_data  <= rf_rd_data;
                  tx_valid <= 1'b1;
                  r_state  <= TX_RD;
               end
               ALU_A: if (rx_valid) begin
                  rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
                  rf_wr_data <= rx_data;
                  rf_wr_en   <= 1'b1;
                  r_state    <= ALU_B;
               end
               ALU_B: if (rx_valid) begin
                  rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
                  rf_wr_data <= rx_data;
                  rf_wr_en   <= 1'b1;
                  r_state    <= ALU_FUN;
               end
               ALU_FUN: if (rx_valid) begin
                  alu_fun <= rx_data[FUN_WIDTH-1:0];
                  alu_en  <= 1'b1;
                  r_state <= ALU_WAIT;
               end
               ALU_WAIT: if (alu_out_valid) begin
                  tx_data   <= alu_out[DATA_WIDTH-1:0];
                  r_alu_msb <= alu_out[DATA_WIDTH +: DATA_WIDTH];
                  tx_valid  <= 1'b1;
                  r_state   <= TX_LSB;
               end
               TX_LSB: if (tx_ready) begin
                  tx_data <= r_alu_msb;
                  r_state <= TX_MSB;
               end
               TX_MSB, TX_RD: if (tx_ready) begin
                  tx_valid <= 1'b0;
                  r_state  <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: directed plus randomized frames checked against a
// transaction-level model of the expected writes, reads, ALU starts, tx bytes and errors.
module tb_cmd_frame_decoder;
   localparam int TO = 1024;

   logic        D_CLK = 1'b0;
   logic        D_RST = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [3:0]  rf_addr;
   logic [7:0]  rf_wr_data;
   logic        rf_wr_en, rf_rd_en;
   logic [7:0]  rf_rd_data = '0;
   logic        rf_rd_valid = 1'b0;
   logic [3:0]  alu_fun;
   logic        alu_en;
   logic [15:0] alu_out = '0;
   logic        alu_out_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        frame_err;

   cmd_frame_decoder dut (
      .D_CLK(D_CLK), .D_RST(D_RST), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
      .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_fun(alu_fun), .alu_en(alu_en),
      .alu_out(alu_out), .alu_out_valid(alu_out_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .frame_err(frame_err)
   );

   always #5 D_CLK = ~D_CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed events and model expectations
   logic [11:0] q_wr[$], e_wr[$];
   logic [3:0]  q_rd[$], e_rd[$], q_alu[$], e_alu[$];
   logic [7:0]  q_tx[$], e_tx[$];
   int          q_txc[$];
   int          err_seen = 0, e_err = 0, cyc = 0;
   logic [7:0]  resp_mem[16];
   logic [7:0]  model_mem[16];

   // Responder knobs: negative latency means random
   int          rd_lat = -1, alu_lat = -1, rd_cnt = 0, alu_cnt = 0, tx_hold = 0;
   bit          rd_pend = 0, alu_pend = 0, rand_rdy = 0, alu_force_en = 0, prev_stall = 0;
   logic [3:0]  rd_a = '0, alu_f = '0;
   logic [15:0] alu_force = '0;
   logic [7:0]  prev_tx = '0;

   function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      return alu_force_en ? alu_force : ({b, a} ^ {12'h000, f});
   endfunction

   // One clock: observe outputs, then drive the inputs for the next rising edge
   task automatic step(input logic v, input logic [7:0] b);
      @(negedge D_CLK);
      cyc++;
      if (prev_stall) begin
         check("tx_hold_valid", 32'(tx_valid), 32'd1);
         check("tx_hold_data", 32'(tx_data), 32'(prev_tx));
      end
      if (rf_wr_en) begin
         q_wr.push_back({rf_addr, rf_wr_data});
         resp_mem[rf_addr] = rf_wr_data;
      end
      if (rf_rd_en) begin
         q_rd.push_back(rf_addr);
         rd_pend = 1;
         rd_a = rf_addr;
         rd_cnt = rd_lat < 0 ? int'($urandom_range(0, 4)) : rd_lat;
      end
      if (alu_en) begin
         q_alu.push_back(alu_fun);
         alu_pend = 1;
         alu_f = alu_fun;
         alu_cnt = alu_lat < 0 ? int'($urandom_range(0, 4)) : alu_lat;
      end
      if (frame_err) err_seen++;
      rx_valid = v;
      rx_data = b;
      rf_rd_valid = 1'b0;
      rf_rd_data = 8'($urandom);
      if (rd_pend) begin
         if (rd_cnt == 0) begin
            rf_rd_valid = 1'b1;
            rf_rd_data = resp_mem[rd_a];
            rd_pend = 0;
         end else rd_cnt--;
      end
      alu_out_valid = 1'b0;
      alu_out = 16'($urandom);
      if (alu_pend) begin
         if (alu_cnt == 0) begin
            alu_out_valid = 1'b1;
            alu_out = alu_calc(resp_mem[0], resp_mem[1], alu_f);
            alu_pend = 0;
         end else alu_cnt--;
      end
      if (tx_valid && tx_hold > 0) begin
         tx_ready = 1'b0;
         tx_hold--;
      end else tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = tx_valid && !tx_ready;
      prev_tx = tx_data;
      if (tx_valid && tx_ready) begin
         q_tx.push_back(tx_data);
         q_txc.push_back(cyc);
      end
   endtask

   task automatic model_frame(input logic [31:0] by);
      logic [15:0] r;
      case (by[7:0])
         8'hAA: begin
            e_wr.push_back({by[11:8], by[23:16]});
            model_mem[by[11:8]] = by[23:16];
         end
         8'hBB: begin
            e_rd.push_back(by[11:8]);
            e_tx.push_back(model_mem[by[11:8]]);
         end
         8'hCC: begin
            e_wr.push_back({4'd0, by[15:8]});
            e_wr.push_back({4'd1, by[23:16]});
            model_mem[0] = by[15:8];
            model_mem[1] = by[23:16];
            e_alu.push_back(by[27:24]);
            r = alu_calc(model_mem[0], model_mem[1], by[27:24]);
            e_tx.push_back(r[7:0]);
            e_tx.push_back(r[15:8]);
         end
         8'hDD: begin
            e_alu.push_back(by[11:8]);
            r = alu_calc(model_mem[0], model_mem[1], by[11:8]);
            e_tx.push_back(r[7:0]);
            e_tx.push_back(r[15:8]);
         end
         default: e_err++;
      endcase
   endtask

   task automatic drain();
      int n = 0;
      int q = 0;
      while (n < 400 && q < 3) begin
         step(1'b0, 8'h00);
         n++;
         q = (rd_pend || alu_pend || tx_valid) ? 0 : q + 1;
      end
      check("drain_bound", 32'(n < 400), 32'd1);
   endtask

   task automatic send(input logic [31:0] by, input int n, input int gap);
      model_frame(by);
      for (int i = 0; i < n; i++) begin
         step(1'b1, by[8*i +: 8]);
         repeat ($urandom_range(0, gap)) step(1'b0, 8'h00);
      end
      drain();
   endtask

   task automatic compare(input string tag);
      check({tag, "_nwr"}, 32'(q_wr.size()), 32'(e_wr.size()));
      for (int i = 0; i < e_wr.size() && i < q_wr.size(); i++) check({tag, "_wr"}, 32'(q_wr[i]), 32'(e_wr[i]));
      check({tag, "_nrd"}, 32'(q_rd.size()), 32'(e_rd.size()));
      for (int i = 0; i < e_rd.size() && i < q_rd.size(); i++) check({tag, "_rd"}, 32'(q_rd[i]), 32'(e_rd[i]));
      check({tag, "_nalu"}, 32'(q_alu.size()), 32'(e_alu.size()));
      for (int i = 0; i < e_alu.size() && i < q_alu.size(); i++) check({tag, "_alu"}, 32'(q_alu[i]), 32'(e_alu[i]));
      check({tag, "_ntx"}, 32'(q_tx.size()), 32'(e_tx.size()));
      for (int i = 0; i < e_tx.size() && i < q_tx.size(); i++) check({tag, "_tx"}, 32'(q_tx[i]), 32'(e_tx[i]));
      check({tag, "_err"}, 32'(err_seen), 32'(e_err));
      q_wr.delete(); e_wr.delete(); q_rd.delete(); e_rd.delete();
      q_alu.delete(); e_alu.delete(); q_tx.delete(); e_tx.delete(); q_txc.delete();
      err_seen = 0;
      e_err = 0;
   endtask

   task automatic check_zero(input string tag);
      check(tag, {rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, tx_data, tx_valid, frame_err}, 32'd0);
   endtask

   initial begin
      logic [7:0] op;
      int n;
      for (int i = 0; i < 16; i++) begin
         resp_mem[i] = '0;
         model_mem[i] = '0;
      end
      repeat (3) step(1'b0, 8'h00);
      check_zero("reset");
      D_RST = 1'b1;
      step(1'b0, 8'h00);
      // Reset while waiting for opA abandons the frame
      step(1'b1, 8'hCC);
      step(1'b0, 8'h00);
      D_RST = 1'b0;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      check_zero("mid_reset");
      D_RST = 1'b1;
      drain();
      compare("post_reset");
      send(32'h0000_07BB, 2, 0);
      compare("rd_after_reset");
      send(32'h003C_05AA, 3, 0);
      compare("wr");
      send(32'h005A_F7AA, 3, 1);
      compare("wr_hi_addr");
      rd_lat = 3;
      tx_hold = 2;
      send(32'h0000_07BB, 2, 0);
      compare("rd_stall");
      rd_lat = -1;
      alu_lat = 2;
      alu_force_en = 1;
      alu_force = 16'h1234;
      send(32'h0120_10CC, 4, 0);
      check("alu_b2b", 32'(q_txc.size() == 2 ? q_txc[1] - q_txc[0] : -1), 32'd1);
      compare("alu_op");
      alu_force_en = 0;
      send(32'h0000_0077, 1, 0);
      compare("bad_op");
      send(32'h0000_02DD, 2, 0);
      compare("alu_nop");
      // Silence after an opcode must time out exactly once
      step(1'b1, 8'hAA);
      n = 0;
      while (n < 2000 && err_seen == 0) begin
         step(1'b0, 8'h00);
         n++;
      end
      check("timeout_cycles", 32'(n), 32'(TO + 1));
      e_err = 1;
      drain();
      compare("timeout");
      // A byte arriving in the expiry cycle is accepted
      model_frame(32'h0099_03AA);
      step(1'b1, 8'hAA);
      repeat (TO - 1) step(1'b0, 8'h00);
      step(1'b1, 8'h03);
      step(1'b1, 8'h99);
      drain();
      compare("timeout_edge");
      // Extra byte during ALU_WAIT is dropped with an error
      alu_lat = 6;
      model_frame(32'h0000_05DD);
      step(1'b1, 8'hDD);
      step(1'b1, 8'h05);
      step(1'b0, 8'h00);
      step(1'b1, 8'h42);
      e_err++;
      drain();
      compare("overrun");
      alu_lat = -1;
      rand_rdy = 1;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 4))
            0: op = 8'hAA;
            1: op = 8'hBB;
            2: op = 8'hCC;
            3: op = 8'hDD;
            default: begin
               op = 8'($urandom);
               while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) op = 8'($urandom);
            end
         endcase
         n = op == 8'hAA ? 3 : op == 8'hBB ? 2 : op == 8'hCC ? 4 : op == 8'hDD ? 2 : 1;
         send({$urandom_range(0, 16777215) << 8} | 32'(op), n, 3);
         compare("rand");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
